// File: rtl/bk_pkg.sv
// bk_pkg: shared types for the backup-RAM sync controller (FSM states, transfer direction, sector size)
package bk_pkg;
   typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
   typedef enum logic {DIR_LOAD, DIR_SAVE} dir_t;
   localparam int SECTOR_BYTES = 512;
endpackage

// File: rtl/bk_edge.sv
// bk_edge: registered 1-bit edge detector; hit = rise (FALL=0) or fall (FALL=1) of d vs. its registered copy
// Ports: clk, rst (async, active-high), d (input level), hit (edge pulse, combinational from d)
module bk_edge #(
   parameter bit FALL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic hit
);
   logic d_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) d_q <= 1'b0;
      else     d_q <= d;
   assign hit = FALL ? (~d & d_q) : (d & ~d_q);
endmodule

// File: rtl/bk_sync_ctrl.sv
// bk_sync_ctrl: sequences NVRAM load/save sector transfers between the save-RAM buffer and the mounted image
// Ports: clk_sys/reset (async, active-high); ioctl_download, img_* and bk_load/bk_save/autosave_en/osd_status
// trigger transfers; nvram_we marks the NVRAM dirty; sd_lba/sd_rd/sd_wr/sd_ack is the hps_io sector handshake;
// bk_ena/bk_loading/bk_busy/bk_dirty/bk_err report status to the OSD, core reset and LED.
module bk_sync_ctrl
   import bk_pkg::*;
#(
   parameter int          SECTORS     = 64,
   parameter int          LBA_W       = 6,
   parameter logic [23:0] ACK_TIMEOUT = 24'd12_000_000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        img_mounted,
   input  logic        img_readonly,
   input  logic        img_size_nz,
   input  logic        bk_load,
   input  logic        bk_save,
   input  logic        autosave_en,
   input  logic        osd_status,
   input  logic        nvram_we,
   input  logic        sd_ack,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        bk_ena,
   output logic        bk_loading,
   output logic        bk_busy,
   output logic        bk_dirty,
   output logic        bk_err
);
   localparam logic [LBA_W-1:0] LAST = LBA_W'(SECTORS - 1);
   state_t state_q, state_d;
   dir_t dir_q, dir_d;
   logic [LBA_W-1:0] cnt_q, cnt_d;
   logic [23:0] tmo_q, tmo_d;
   logic rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, loading_q, loading_d;
   logic err_q, err_d, dirty_q, dirty_d, ena_q, ena_d;
   logic dl_rise, dl_fall, ld_rise, sv_rise, osd_rise, ack_rise, ack_fall;
   logic start_load, start_save;

   bk_edge #(.FALL(1'b0)) u_dl_rise  (.clk(clk_sys), .rst(reset), .d(ioctl_download),  .hit(dl_rise));
   bk_edge #(.FALL(1'b1)) u_dl_fall  (.clk(clk_sys), .rst(reset), .d(ioctl_download),  .hit(dl_fall));
   bk_edge #(.FALL(1'b0)) u_ld_rise  (.clk(clk_sys), .rst(reset), .d(bk_load & ena_q), .hit(ld_rise));
   bk_edge #(.FALL(1'b0)) u_sv_rise  (.clk(clk_sys), .rst(reset), .d(bk_save & ena_q), .hit(sv_rise));
   bk_edge #(.FALL(1'b0)) u_osd_rise (.clk(clk_sys), .rst(reset), .d(osd_status),      .hit(osd_rise));
   bk_edge #(.FALL(1'b0)) u_ack_rise (.clk(clk_sys), .rst(reset), .d(sd_ack),          .hit(ack_rise));
   bk_edge #(.FALL(1'b1)) u_ack_fall (.clk(clk_sys), .rst(reset), .d(sd_ack),          .hit(ack_fall));

   // Auto-load outranks manual load; any load outranks any save.
   assign start_load = (dl_fall & img_size_nz & ena_q) | ld_rise;
   assign start_save = sv_rise | (osd_rise & autosave_en & dirty_q & ena_q);

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      busy_d    = busy_q;
      loading_d = loading_q;
      err_d     = err_q;
      dirty_d   = dirty_q;
      ena_d     = dl_rise ? 1'b0 : (ioctl_download & img_mounted & ~img_readonly) ? 1'b1 : ena_q;
      unique case (state_q)
         IDLE: if (start_load || start_save) begin
            state_d   = REQ;
            dir_d     = start_load ? DIR_LOAD : DIR_SAVE;
            cnt_d     = '0;
            tmo_d     = '0;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            loading_d = start_load;
            rd_d      = start_load;
            wr_d      = ~start_load;
            dirty_d   = start_load ? dirty_q : 1'b0;
         end
         REQ: if (ack_rise) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            tmo_d   = '0;
            state_d = XFER;
         end else if (tmo_q == ACK_TIMEOUT - 24'd1) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            tmo_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
         end else begin
            tmo_d = tmo_q + 24'd1;
         end
         XFER: if (ack_fall) begin
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = REQ;
               rd_d    = (dir_q == DIR_LOAD);
               wr_d    = (dir_q == DIR_SAVE);
            end
         end
         DONE: begin
            busy_d    = 1'b0;
            loading_d = 1'b0;
            cnt_d     = '0;
            state_d   = IDLE;
            if (dir_q == DIR_LOAD && !err_q) dirty_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // A write always wins over the clear at save accept; writes during a load are image data, not edits.
      if (nvram_we && !loading_q) dirty_d = 1'b1;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         dir_q     <= DIR_LOAD;
         cnt_q     <= '0;
         tmo_q     <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         loading_q <= 1'b0;
         err_q     <= 1'b0;
         dirty_q   <= 1'b0;
         ena_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         busy_q    <= busy_d;
         loading_q <= loading_d;
         err_q     <= err_d;
         dirty_q   <= dirty_d;
         ena_q     <= ena_d;
      end
   end

   assign sd_lba     = {{(32 - LBA_W){1'b0}}, cnt_q};
   assign sd_rd      = rd_q;
   assign sd_wr      = wr_q;
   assign bk_ena     = ena_q;
   assign bk_loading = loading_q;
   assign bk_busy    = busy_q;
   assign bk_dirty   = dirty_q;
   assign bk_err     = err_q;
endmodule

// File: tb/tb_bk_sync_ctrl.sv
// tb_bk_sync_ctrl: directed scenarios for bk_sync_ctrl (64 sectors, ack timeout shortened to 100 cycles)
module tb_bk_sync_ctrl;
   logic clk_sys = 1'b0, reset = 1'b1;
   logic ioctl_download = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0, img_size_nz = 1'b1;
   logic bk_load = 1'b0, bk_save = 1'b0, autosave_en = 1'b0, osd_status = 1'b0;
   logic nvram_we = 1'b0, sd_ack = 1'b0;
   logic [31:0] sd_lba;
   logic sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err;
   int passed = 0, total = 0;

   always #5 clk_sys = ~clk_sys;

   bk_sync_ctrl #(.SECTORS(64), .LBA_W(6), .ACK_TIMEOUT(24'd100)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .img_mounted(img_mounted),
      .img_readonly(img_readonly), .img_size_nz(img_size_nz), .bk_load(bk_load), .bk_save(bk_save),
      .autosave_en(autosave_en), .osd_status(osd_status), .nvram_we(nvram_we), .sd_ack(sd_ack),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena), .bk_loading(bk_loading),
      .bk_busy(bk_busy), .bk_dirty(bk_dirty), .bk_err(bk_err)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic download(input bit ro);
      ioctl_download = 1'b1;
      tick();
      img_mounted  = 1'b1;
      img_readonly = ro;
      tick();
      img_mounted  = 1'b0;
      tick();
   endtask

   // Serves nsec sectors; pulses nvram_we while sector we_at is acked.
   task automatic xfer(input bit ld, input int nsec, input int we_at);
      for (int i = 0; i < nsec; i++) begin
         int k;
         k = 0;
         while (!(sd_rd || sd_wr) && k < 200) begin
            tick();
            k++;
         end
         total++;
         if (k >= 200) $display("FAIL xfer_req sector %0d: no request in 200 cycles", i);
         else passed++;
         total++;
         if ({sd_rd, sd_wr, bk_busy, bk_loading} !== {ld, !ld, 1'b1, ld} || sd_lba !== 32'(i))
            $display("FAIL xfer_req_state sector %0d: rd/wr/busy/loading=%b lba=%0d, expected %b lba=%0d",
                     i, {sd_rd, sd_wr, bk_busy, bk_loading}, sd_lba, {ld, !ld, 1'b1, ld}, i);
         else passed++;
         sd_ack = 1'b1;
         tick();
         total++;
         if ({sd_rd, sd_wr} !== 2'b00) $display("FAIL xfer_drop sector %0d: rd/wr=%b, expected 00", i, {sd_rd, sd_wr});
         else passed++;
         if (i == we_at) begin
            nvram_we = 1'b1;
            tick();
            nvram_we = 1'b0;
         end else tick();
         sd_ack = 1'b0;
         tick();
      end
      if (nsec == 64) begin
         total++;
         if (bk_busy !== 1'b1) $display("FAIL xfer_busy_hold: busy=%b, expected 1", bk_busy);
         else passed++;
         tick();
         total++;
         if ({bk_busy, bk_loading, sd_rd, sd_wr} !== 4'b0000)
            $display("FAIL xfer_end: busy/loading/rd/wr=%b, expected 0000", {bk_busy, bk_loading, sd_rd, sd_wr});
         else passed++;
      end
   endtask

   task automatic test_reset;
      tick(2);
      total++;
      if ({sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err} !== 7'b0)
         $display("FAIL reset_flags: %b, expected 0000000", {sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err});
      else passed++;
      total++;
      if (sd_lba !== 32'd0) $display("FAIL reset_lba: %0d, expected 0", sd_lba);
      else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_autoload;
      download(1'b0);
      total++;
      if (bk_ena !== 1'b1) $display("FAIL autoload_ena: %b, expected 1", bk_ena);
      else passed++;
      ioctl_download = 1'b0;
      tick();
      total++;
      if ({sd_rd, sd_wr, bk_loading} !== 3'b101) $display("FAIL autoload_start: rd/wr/loading=%b, expected 101", {sd_rd, sd_wr, bk_loading});
      else passed++;
      xfer(1'b1, 64, -1);
      total++;
      if ({bk_dirty, bk_err} !== 2'b00) $display("FAIL autoload_flags: dirty/err=%b, expected 00", {bk_dirty, bk_err});
      else passed++;
   endtask

   task automatic test_autosave;
      autosave_en = 1'b1;
      nvram_we = 1'b1;
      tick();
      nvram_we = 1'b0;
      total++;
      if (bk_dirty !== 1'b1) $display("FAIL autosave_dirty_set: %b, expected 1", bk_dirty);
      else passed++;
      osd_status = 1'b1;
      tick();
      total++;
      if ({sd_rd, sd_wr, bk_dirty} !== 3'b010) $display("FAIL autosave_start: rd/wr/dirty=%b, expected 010", {sd_rd, sd_wr, bk_dirty});
      else passed++;
      xfer(1'b0, 64, -1);
      total++;
      if (bk_dirty !== 1'b0) $display("FAIL autosave_dirty_end: %b, expected 0", bk_dirty);
      else passed++;
      osd_status = 1'b0;
      tick();
   endtask

   task automatic test_write_during_save;
      nvram_we = 1'b1;
      tick();
      nvram_we = 1'b0;
      osd_status = 1'b1;
      tick();
      xfer(1'b0, 64, 10);
      total++;
      if (bk_dirty !== 1'b1) $display("FAIL save_write_dirty: %b, expected 1", bk_dirty);
      else passed++;
      osd_status = 1'b0;
      tick();
   endtask

   task automatic test_load_save_same;
      bit seen;
      bk_load = 1'b1;
      bk_save = 1'b1;
      tick();
      total++;
      if ({sd_rd, sd_wr} !== 2'b10) $display("FAIL same_cycle_dir: rd/wr=%b, expected 10", {sd_rd, sd_wr});
      else passed++;
      xfer(1'b1, 64, 3);
      total++;
      if (bk_dirty !== 1'b0) $display("FAIL load_clears_dirty: %b, expected 0", bk_dirty);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen |= sd_rd | sd_wr;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL same_cycle_dropped: request seen=%b, expected 0", seen);
      else passed++;
      bk_load = 1'b0;
      bk_save = 1'b0;
      tick();
   endtask

   task automatic test_timeout;
      int n;
      bk_load = 1'b1;
      tick();
      n = 0;
      while (sd_rd && n < 300) begin
         n++;
         tick();
      end
      total++;
      if (n !== 100) $display("FAIL timeout_len: sd_rd high %0d cycles, expected 100", n);
      else passed++;
      total++;
      if (bk_err !== 1'b1) $display("FAIL timeout_err: %b, expected 1", bk_err);
      else passed++;
      tick();
      total++;
      if ({bk_busy, bk_loading, bk_err} !== 3'b001) $display("FAIL timeout_idle: busy/loading/err=%b, expected 001", {bk_busy, bk_loading, bk_err});
      else passed++;
      bk_load = 1'b0;
      tick();
      bk_load = 1'b1;
      tick();
      total++;
      if ({bk_err, sd_rd} !== 2'b01) $display("FAIL timeout_err_clear: err/rd=%b, expected 01", {bk_err, sd_rd});
      else passed++;
      xfer(1'b1, 64, -1);
      bk_load = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      bit seen;
      int k;
      nvram_we = 1'b1;
      tick();
      nvram_we = 1'b0;
      bk_save = 1'b1;
      tick();
      total++;
      if ({sd_wr, bk_dirty} !== 2'b10) $display("FAIL save_accept_clear: wr/dirty=%b, expected 10", {sd_wr, bk_dirty});
      else passed++;
      xfer(1'b0, 5, -1);
      k = 0;
      while (!sd_wr && k < 200) begin
         tick();
         k++;
      end
      total++;
      if (sd_lba !== 32'd5 || sd_wr !== 1'b1) $display("FAIL mid_sector5: lba=%0d wr=%b, expected 5 1", sd_lba, sd_wr);
      else passed++;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err} !== 7'b0 || sd_lba !== 32'd0)
         $display("FAIL async_reset: flags=%b lba=%0d, expected 0000000 0",
                  {sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty, bk_err}, sd_lba);
      else passed++;
      tick();
      reset = 1'b0;
      bk_save = 1'b0;
      tick();
      bk_save = 1'b1;
      bk_load = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen |= sd_rd | sd_wr;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL post_reset_disarmed: request seen=%b, expected 0", seen);
      else passed++;
      bk_save = 1'b0;
      bk_load = 1'b0;
      download(1'b0);
      ioctl_download = 1'b0;
      tick();
      total++;
      if ({bk_ena, sd_rd} !== 2'b11) $display("FAIL rearm_autoload: ena/rd=%b, expected 11", {bk_ena, sd_rd});
      else passed++;
      xfer(1'b1, 64, -1);
   endtask

   task automatic test_readonly;
      bit seen;
      download(1'b1);
      total++;
      if (bk_ena !== 1'b0) $display("FAIL readonly_ena: %b, expected 0", bk_ena);
      else passed++;
      ioctl_download = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bk_load = (i >= 10 && i < 15);
         tick();
         seen |= sd_rd | sd_wr;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL readonly_no_req: request seen=%b, expected 0", seen);
      else passed++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_autoload();
      test_autosave();
      test_write_during_save();
      test_load_save_same();
      test_timeout();
      test_reset_mid();
      test_readonly();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
